// File: rtl/card_shoe_datapath.sv
// card_shoe_datapath: card registers, finite shoe and hand scoring for the
// baccarat round controller. Each load_* strobe captures one card from a
// shoe of DECKS decks. An exhausted rank is replaced by the next rank that
// still has copies, wrapping from K back to A.
module card_shoe_datapath #(
  parameter int DECKS = 1
) (
  input  logic                              slow_clock,
  input  logic                              reset,
  input  logic [3:0]                        new_card,
  input  logic                              load_pcard1,
  input  logic                              load_pcard2,
  input  logic                              load_pcard3,
  input  logic                              load_dcard1,
  input  logic                              load_dcard2,
  input  logic                              load_dcard3,
  input  logic                              clear_hand,
  input  logic                              reshuffle,
  output logic [3:0]                        pcard1,
  output logic [3:0]                        pcard2,
  output logic [3:0]                        pcard3,
  output logic [3:0]                        dcard1,
  output logic [3:0]                        dcard2,
  output logic [3:0]                        dcard3,
  output logic [3:0]                        pscore,
  output logic [3:0]                        dscore,
  output logic [$clog2(52*DECKS+1)-1:0]     cards_left,
  output logic                              shoe_empty,
  output logic                              multi_load_err
);

  localparam int CLW = $clog2(52*DECKS+1);
  localparam int CW  = $clog2(4*DECKS+1);
  localparam logic [CLW-1:0] SHOE_FULL = CLW'(52*DECKS);
  localparam logic [CW-1:0]  RANK_FULL = CW'(4*DECKS);

  // Remaining copies of each rank; index 0 holds aces, index 12 holds kings.
  logic [CW-1:0] rank_count [13];

  logic [5:0] load_vec;
  logic [5:0] load_sel;
  logic       any_load;
  logic       multi_load;
  logic [3:0] req_idx;
  logic [3:0] chosen_idx;
  logic       chosen_found;
  logic [3:0] chosen_rank;

  // Card value for scoring: 1..9 count face value, ten/court/empty count 0.
  function automatic logic [4:0] card_value(input logic [3:0] r);
    card_value = (r <= 4'd9) ? {1'b0, r} : 5'd0;
  endfunction

  // Sum of three card values reduced modulo 10; the sum never exceeds 27.
  function automatic logic [3:0] hand_score(input logic [3:0] a,
                                            input logic [3:0] b,
                                            input logic [3:0] c);
    logic [4:0] sum;
    logic [4:0] red;
    sum = card_value(a) + card_value(b) + card_value(c);
    if (sum >= 5'd20)
      red = sum - 5'd20;
    else if (sum >= 5'd10)
      red = sum - 5'd10;
    else
      red = sum;
    hand_score = red[3:0];
  endfunction

  // Strobe decode: bit 0 (pcard1) has the highest priority, so isolating the
  // lowest set bit selects the single slot that actually loads.
  always_comb begin
    load_vec   = {load_dcard3, load_dcard2, load_dcard1,
                  load_pcard3, load_pcard2, load_pcard1};
    load_sel   = load_vec & (~load_vec + 6'd1);
    any_load   = (load_vec != 6'd0);
    multi_load = ((load_vec & (load_vec - 6'd1)) != 6'd0);
  end

  // Rank selection: out-of-range requests become aces, then walk upward from
  // the requested rank with wraparound until a rank with copies left is found.
  always_comb begin
    logic [4:0] cand;
    req_idx      = ((new_card == 4'd0) || (new_card > 4'd13)) ? 4'd0 : (new_card - 4'd1);
    chosen_idx   = 4'd0;
    chosen_found = 1'b0;
    cand         = 5'd0;
    for (int i = 0; i < 13; i++) begin
      cand = {1'b0, req_idx} + 5'(i);
      if (cand >= 5'd13)
        cand = cand - 5'd13;
      if (!chosen_found && (rank_count[cand[3:0]] != '0)) begin
        chosen_found = 1'b1;
        chosen_idx   = cand[3:0];
      end
    end
    chosen_rank = chosen_found ? (chosen_idx + 4'd1) : 4'd0;
  end

  // Shoe and card state: reshuffle/clear_hand take precedence over loads,
  // and a load draws exactly one card (or stores 0 once the shoe is empty).
  always_ff @(posedge slow_clock or posedge reset) begin
    if (reset) begin
      pcard1         <= 4'd0;
      pcard2         <= 4'd0;
      pcard3         <= 4'd0;
      dcard1         <= 4'd0;
      dcard2         <= 4'd0;
      dcard3         <= 4'd0;
      cards_left     <= SHOE_FULL;
      multi_load_err <= 1'b0;
      for (int i = 0; i < 13; i++)
        rank_count[i] <= RANK_FULL;
    end else begin
      if (multi_load)
        multi_load_err <= 1'b1;
      if (reshuffle || clear_hand) begin
        if (reshuffle) begin
          cards_left <= SHOE_FULL;
          for (int i = 0; i < 13; i++)
            rank_count[i] <= RANK_FULL;
        end
        if (clear_hand) begin
          pcard1 <= 4'd0;
          pcard2 <= 4'd0;
          pcard3 <= 4'd0;
          dcard1 <= 4'd0;
          dcard2 <= 4'd0;
          dcard3 <= 4'd0;
        end
      end else if (any_load) begin
        if (load_sel[0]) pcard1 <= chosen_rank;
        if (load_sel[1]) pcard2 <= chosen_rank;
        if (load_sel[2]) pcard3 <= chosen_rank;
        if (load_sel[3]) dcard1 <= chosen_rank;
        if (load_sel[4]) dcard2 <= chosen_rank;
        if (load_sel[5]) dcard3 <= chosen_rank;
        if (chosen_found) begin
          rank_count[chosen_idx] <= rank_count[chosen_idx] - CW'(1);
          cards_left             <= cards_left - CLW'(1);
        end
      end
    end
  end

  // Scores and the empty flag are pure functions of the registered state.
  always_comb begin
    pscore     = hand_score(pcard1, pcard2, pcard3);
    dscore     = hand_score(dcard1, dcard2, dcard3);
    shoe_empty = (cards_left == '0);
  end

endmodule
